// File: rtl/spi_slave_if.sv
// spi_slave_if: mode-0 SPI slave decoding command/data frames into register file reads and writes
module spi_slave_if #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [DATA_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_frame_err
);
  localparam int CW = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sclk_s_q, cs_s_q, mosi_s_q;
  logic sclk_dly_q, cs_dly_q;
  logic [DATA_W-2:0] rx_q, tx_q;
  logic [CW-1:0] cnt_q;
  logic wr_flag_q, miso_q;
  logic sclk, cs_n, mosi, rise, fall, cs_rise, cs_fall, last_cmd, last_data;
  assign sclk = sclk_s_q[SYNC_STAGES-1];
  assign cs_n = cs_s_q[SYNC_STAGES-1];
  assign mosi = mosi_s_q[SYNC_STAGES-1];
  assign rise = sclk & ~sclk_dly_q;
  assign fall = ~sclk & sclk_dly_q;
  assign cs_rise = cs_n & ~cs_dly_q;
  assign cs_fall = ~cs_n & cs_dly_q;
  assign last_cmd = rise && cnt_q == CW'(DATA_W - 1);
  assign last_data = rise && cnt_q == CW'(2 * DATA_W - 1);
  assign o_miso_oe = ~cs_n;
  assign o_miso = miso_q & ~cs_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q <= '0;
      cs_s_q <= '1;
      mosi_s_q <= '0;
      sclk_dly_q <= 1'b0;
      cs_dly_q <= 1'b1;
    end else begin
      sclk_s_q <= {sclk_s_q[SYNC_STAGES-2:0], i_sclk};
      cs_s_q <= {cs_s_q[SYNC_STAGES-2:0], i_cs_n};
      mosi_s_q <= {mosi_s_q[SYNC_STAGES-2:0], i_mosi};
      sclk_dly_q <= sclk;
      cs_dly_q <= cs_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_q <= '0;
      tx_q <= '0;
      cnt_q <= '0;
      wr_flag_q <= 1'b0;
      miso_q <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      o_wr <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr <= 1'b0;
      o_frame_err <= 1'b0;
      case (state_q)
        IDLE: if (cs_fall) begin
          cnt_q <= '0;
          rx_q <= '0;
          miso_q <= 1'b0;
          state_q <= CMD;
        end
        CMD: if (cs_rise) begin
          o_frame_err <= 1'b1;
          state_q <= IDLE;
        end else if (rise) begin
          rx_q <= {rx_q[DATA_W-3:0], mosi};
          cnt_q <= cnt_q + 1'b1;
          if (last_cmd) begin
            o_addr <= {1'b0, rx_q[DATA_W-3:0], mosi};
            wr_flag_q <= rx_q[DATA_W-2];
            state_q <= DATA;
          end
        end
        DATA: if (last_data) begin
          if (wr_flag_q) begin
            o_wdata <= {rx_q, mosi};
            o_wr <= 1'b1;
          end
          state_q <= cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          o_frame_err <= 1'b1;
          state_q <= IDLE;
        end else begin
          if (rise) begin
            rx_q <= {rx_q[DATA_W-3:0], mosi};
            cnt_q <= cnt_q + 1'b1;
          end
          if (fall && !wr_flag_q) begin
            if (cnt_q == CW'(DATA_W)) begin
              tx_q <= i_rdata[DATA_W-2:0];
              miso_q <= i_rdata[DATA_W-1];
            end else begin
              tx_q <= {tx_q[DATA_W-3:0], 1'b0};
              miso_q <= tx_q[DATA_W-2];
            end
          end
        end
        DONE: if (cs_rise) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: scoreboard bench for spi_slave_if write, read, abort, overlong and reset frames
module tb_spi_slave_if;
  logic clk = 1'b0;
  logic rst, i_sclk, i_cs_n, i_mosi;
  logic o_miso, o_miso_oe, o_wr, o_frame_err;
  logic [15:0] o_addr, o_wdata, i_rdata, rd1;
  logic [15:0] mem [0:63];
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  always #5 clk = ~clk;
  spi_slave_if #(.SYNC_STAGES(2), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_wr(o_wr), .i_rdata(i_rdata), .o_frame_err(o_frame_err)
  );
  always @(posedge clk) begin
    rd1 <= mem[o_addr[5:0]];
    i_rdata <= rd1;
    if (o_wr) mem[o_addr[5:0]] <= o_wdata;
  end
  always @(negedge clk) begin
    if (o_frame_err) err_cnt++;
    if (o_wr) begin
      logic [31:0] e;
      wr_cnt++;
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", o_addr, o_wdata);
      end else begin
        e = exp_wr.pop_front();
        if ({o_addr, o_wdata} !== e) begin
          n_fail++;
          $display("FAIL write_value: got %h, required %h", {o_addr, o_wdata}, e);
        end
      end
    end
  end
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cs_low;
    i_cs_n = 1'b0;
    clks(6);
  endtask
  task automatic cs_high;
    clks(6);
    i_cs_n = 1'b1;
    clks(10);
  endtask
  task automatic shift(input logic [63:0] bits, input int n, output logic [63:0] mi, output logic any);
    mi = '0;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_mosi = bits[63-i];
      clks(5);
      mi[63-i] = o_miso;
      any = any | o_miso;
      i_sclk = 1'b1;
      clks(5);
      i_sclk = 1'b0;
    end
  endtask
  task automatic check_counts(input string name, input int w0, input int dw, input int e0, input int de);
    n_checks++;
    if (wr_cnt - w0 !== dw || err_cnt - e0 !== de || exp_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_counts: got writes %0d errs %0d pending %0d, required writes %0d errs %0d pending 0",
               name, wr_cnt - w0, err_cnt - e0, exp_wr.size(), dw, de);
    end
  endtask
  task automatic read_frame(input logic [15:0] addr, input logic [15:0] expv);
    logic [63:0] mi;
    logic any;
    logic [15:0] want;
    exp_rd.push_back(expv);
    cs_low();
    shift({addr, 48'h0}, 16, mi, any);
    n_checks++;
    if (o_addr !== {1'b0, addr[14:0]}) begin
      n_fail++;
      $display("FAIL read_addr: got %h, required %h", o_addr, {1'b0, addr[14:0]});
    end
    shift(64'h0, 16, mi, any);
    want = exp_rd.pop_front();
    n_checks++;
    if (mi[63:48] !== want) begin
      n_fail++;
      $display("FAIL read_miso: got %h, required %h", mi[63:48], want);
    end
    cs_high();
  endtask
  task automatic test_reset;
    rst = 1'b1;
    i_sclk = 1'b0;
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    clks(4);
    n_checks++;
    if ({o_addr, o_wdata, o_wr, o_miso, o_miso_oe, o_frame_err} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {o_addr, o_wdata, o_wr, o_miso, o_miso_oe, o_frame_err});
    end
    rst = 1'b0;
    clks(4);
  endtask
  task automatic test_write;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    exp_wr.push_back({16'h0000, 16'h1234});
    cs_low();
    shift({16'h8000, 16'h1234, 32'h0}, 32, mi, any);
    cs_high();
    n_checks++;
    if (any !== 1'b0) begin
      n_fail++;
      $display("FAIL write_miso: got %b, required 0", any);
    end
    check_counts("write", w0, 1, e0, 0);
  endtask
  task automatic test_read;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    read_frame(16'h0002, 16'h0001);
    check_counts("read", w0, 0, e0, 0);
  endtask
  task automatic test_abort;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    cs_low();
    shift({16'h8004, 4'hF, 44'h0}, 20, mi, any);
    cs_high();
    check_counts("abort", w0, 0, e0, 1);
    n_checks++;
    if (o_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL abort_addr_hold: got %h, required 0004", o_addr);
    end
    w0 = wr_cnt;
    e0 = err_cnt;
    exp_wr.push_back({16'h0004, 16'h0001});
    cs_low();
    shift({16'h8004, 16'h0001, 32'h0}, 32, mi, any);
    cs_high();
    check_counts("abort_retry", w0, 1, e0, 0);
  endtask
  task automatic test_overlong;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    exp_wr.push_back({16'h0000, 16'hABCD});
    cs_low();
    shift({16'h8000, 16'hABCD, 8'hFF, 24'h0}, 40, mi, any);
    n_checks++;
    if (any !== 1'b0) begin
      n_fail++;
      $display("FAIL overlong_miso: got %b, required 0", any);
    end
    cs_high();
    check_counts("overlong", w0, 1, e0, 0);
  endtask
  task automatic test_reset_midframe;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    cs_low();
    shift({16'h8003, 16'h5555, 32'h0}, 20, mi, any);
    rst = 1'b1;
    clks(1);
    n_checks++;
    if ({o_addr, o_wdata, o_wr, o_miso, o_miso_oe, o_frame_err} !== 38'h0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got %h, required 0", {o_addr, o_wdata, o_wr, o_miso, o_miso_oe, o_frame_err});
    end
    i_cs_n = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(5);
    check_counts("midframe_reset", w0, 0, e0, 0);
    read_frame(16'h000A, 16'h0001);
  endtask
  task automatic test_back_to_back;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    exp_wr.push_back({16'h0000, 16'h0010});
    cs_low();
    shift({16'h8000, 16'h0010, 32'h0}, 32, mi, any);
    clks(6);
    i_cs_n = 1'b1;
    clks(20);
    read_frame(16'h0000, 16'h0010);
    check_counts("back_to_back", w0, 1, e0, 0);
  endtask
  task automatic test_cs_with_last_rise;
    logic [63:0] mi;
    logic any;
    int w0 = wr_cnt;
    int e0 = err_cnt;
    exp_wr.push_back({16'h0007, 16'hBEEF});
    cs_low();
    shift({16'h8007, 16'hBEEF, 32'h0}, 31, mi, any);
    i_mosi = 1'b1;
    clks(5);
    i_sclk = 1'b1;
    i_cs_n = 1'b1;
    clks(5);
    i_sclk = 1'b0;
    clks(10);
    check_counts("cs_last_rise", w0, 1, e0, 0);
    read_frame(16'h0007, 16'hBEEF);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hF0F0 ^ 16'(i);
    mem[2] = 16'h0001;
    mem[10] = 16'h0001;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overlong();
    test_reset_midframe();
    test_back_to_back();
    test_cs_with_last_rise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI slave front-end that sits directly upstream of the SPI register file and drives its address, write-data and write-strobe inputs. It oversamples the external SPI pins (mode 0) on the system clock and decodes 32-bit frames, each a 16-bit command word followed by a 16-bit data word. For writes it issues a single-cycle write strobe. For reads it presents the address, captures the register file's read data and shifts it out on MISO in the same frame.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchroniser stages on sclk, cs_n and mosi (minimum 2).
DATA_W, 16, width of the command word and the data word; frame length = 2*DATA_W.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_sclk  input  1  SPI serial clock, asynchronous; CPOL=0
i_cs_n  input  1  SPI chip select, active-low, asynchronous
i_mosi  input  1  SPI master-out data, asynchronous
o_miso  output  1  SPI master-in data
o_miso_oe  output  1  MISO output enable; 1 while the synchronised cs_n is low
o_addr  output  16  register address to the register file; zero-extended cmd[14:0]
o_wdata  output  16  write data to the register file
o_wr  output  1  write strobe, exactly one clk wide per write frame
i_rdata  input  16  registered read data from the register file
o_frame_err  output  1  one-clk pulse when a frame is aborted before 32 bits

Behaviour:
- Reset (rst=1 at posedge clk): all of the following are 0: o_addr, o_wdata, o_wr, o_miso, o_miso_oe, o_frame_err, shift registers, bit counter. Synchroniser registers reset to idle levels: sclk=0, cs_n=1, mosi=0. State goes to IDLE. Reset mid-frame discards the frame with no write and no frame_err.
- Input synchronisation: all three pins pass through SYNC_STAGES flops. Edge detection compares the last stage with a delayed copy.
  - Rise/fall events occur SYNC_STAGES+1 clks after the pin edge.
  - Supported condition: sclk high and low phases are each ≥4 clk periods.
- Command word, bits 15..0:
  - bit15: 1 = write, 0 = read.
  - bits 14:0: address.
  - Data word: bits 15..0. Both words are sent MSB first.
- MOSI is sampled on the sclk rise event. MISO is updated on the sclk fall event.
- State machine:
  - IDLE: wait for cs_n fall event. On it: bit counter=0, rx shift register cleared, o_miso=0, go to CMD.
  - CMD: shift in 16 bits. On the 16th rise:
    - o_addr <= {1'b0, cmd[14:0]} in the same clk.
    - Latch the wr flag.
    - Go to DATA.
    - o_wr remains 0, so the register file performs a read of o_addr and i_rdata is valid 2 clks later.
  - DATA:
    - Read frame: on the first fall event in DATA, load tx shift register <= i_rdata and drive o_miso <= i_rdata[15]. Each later fall shifts the next bit out.
    - Write frame: o_miso is held at 0.
    - On the 16th data rise (32nd overall), a write frame gives o_wdata <= {rx[14:0], mosi} and o_wr=1 for exactly one clk, then state goes to DONE.
    - A read frame goes to DONE with no strobe.
  - DONE: ignore all further sclk edges; no further writes. On cs_n rise event go to IDLE.
- Abort: cs_n rise event in CMD or DATA before the 32nd rise gives o_frame_err=1 for one clk, no o_wr, state goes to IDLE, and o_addr keeps its last value.
- o_addr holds its value between frames. o_wr=0 outside the strobe cycle.
- While o_miso_oe=0, o_miso is 0.
- Simultaneous 32nd rise event and cs_n rise event in the same clk: the write completes (o_wr pulses), no frame_err, state goes to IDLE.
- cs_n fall event while not in IDLE (glitch after DONE, before rise seen) is ignored until IDLE is reached.

Test Plan:
- Write frame MOSI=0x8000 then 0x1234 with sclk=10 clk period -> single o_wr pulse with o_addr=0x0000, o_wdata=0x1234; o_frame_err stays 0.
- Read frame MOSI=0x0002, register file model returns i_rdata=0x0001 for addr 2 -> o_addr=0x0002 after the 16th bit, MISO bits 17..32 = 0x0001 MSB first, o_wr never asserted.
- Abort: write command 0x8004 then 4 data bits, cs_n deasserted -> o_frame_err one-clk pulse, no o_wr, next full write frame to addr 4 with data 0x0001 succeeds.
- Overlong frame: 40 sclk cycles with command 0x8000, data 0xABCD -> exactly one o_wr with wdata 0xABCD; trailing bits ignored; MISO=0 throughout.
- rst=1 asserted after 20 bits of a write frame -> all outputs 0 next clk, no o_wr; subsequent read of addr 0x000A with i_rdata=0x0001 shifts out 0x0001.
- Back-to-back frames separated by 2 sclk periods of cs_n high: write 0x0010 to addr 0, then read addr 0 with i_rdata=0x0010 -> second frame MISO = 0x0010.
